// File: rtl/led_blinker_bank.sv
// led_blinker_bank: N_CH independent LED channels (OFF / ON / BLINK / ONESHOT) with runtime half-period.
// Optional macro LED_BLINK_SYNC_EN adds sync_restart to phase-align all running channels.
module led_blinker_bank #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 26,
  parameter int DEFAULT_PERIOD = 50000000,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [1:0]       wr_mode,
`ifdef LED_BLINK_SYNC_EN
  input  logic             sync_restart,
`endif
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  mode_t            mode_r   [N_CH];
  mode_t            mode_n_s [N_CH];
  logic [CNT_W-1:0] period_r [N_CH];
  logic [CNT_W-1:0] period_n_s [N_CH];
  logic [CNT_W-1:0] cnt_r    [N_CH];
  logic [CNT_W-1:0] cnt_n_s  [N_CH];
  logic [CNT_W-1:0] p_eff_s  [N_CH];
  logic [N_CH-1:0]  led_r, tick_r, busy_r;
  logic [N_CH-1:0]  led_n_s, tick_n_s, busy_n_s;
  logic [N_CH-1:0]  wr_hit_s, expire_s, sync_hit_s;

  // Per-channel decode: write target, period expiry and sync restart request.
  always_comb begin
    wr_hit_s   = '0;
    expire_s   = '0;
    sync_hit_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      // A zero period behaves as a one-cycle period.
      p_eff_s[i]  = (period_r[i] == '0) ? CNT_W'(1) : period_r[i];
      wr_hit_s[i] = wr_en && (int'(wr_ch) < N_CH) && (wr_ch == CH_W'(i));
      expire_s[i] = (cnt_r[i] == (p_eff_s[i] - CNT_W'(1)));
`ifdef LED_BLINK_SYNC_EN
      sync_hit_s[i] = sync_restart && ((mode_r[i] == MODE_BLINK) || (mode_r[i] == MODE_ONESHOT));
`else
      sync_hit_s[i] = 1'b0;
`endif
    end
  end

  // Mode state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_CH; i++) mode_r[i] <= MODE_BLINK;
    end else begin
      for (int i = 0; i < N_CH; i++) mode_r[i] <= mode_n_s[i];
    end
  end

  // Next-state logic: writes load a mode, an expiring one-shot falls back to OFF.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mode_n_s[i] = mode_r[i];
      if (wr_hit_s[i]) begin
        mode_n_s[i] = mode_t'(wr_mode);
      end else if (!sync_hit_s[i] && (mode_r[i] == MODE_ONESHOT) && expire_s[i]) begin
        mode_n_s[i] = MODE_OFF;
      end else begin
        mode_n_s[i] = mode_r[i];
      end
    end
  end

  // Output/datapath logic; priority is write, then sync restart, then counting.
  always_comb begin
    led_n_s  = led_r;
    busy_n_s = busy_r;
    tick_n_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      period_n_s[i] = period_r[i];
      cnt_n_s[i]    = cnt_r[i];
      if (wr_hit_s[i]) begin
        period_n_s[i] = wr_period;
        cnt_n_s[i]    = '0;
        led_n_s[i]    = (wr_mode == 2'd1) || (wr_mode == 2'd3);
        busy_n_s[i]   = (wr_mode == 2'd3);
      end else if (sync_hit_s[i]) begin
        cnt_n_s[i]  = '0;
        led_n_s[i]  = (mode_r[i] == MODE_ONESHOT);
        busy_n_s[i] = (mode_r[i] == MODE_ONESHOT);
      end else begin
        case (mode_r[i])
          MODE_BLINK: begin
            if (expire_s[i]) begin
              cnt_n_s[i]  = '0;
              led_n_s[i]  = ~led_r[i];
              tick_n_s[i] = 1'b1;
            end else begin
              cnt_n_s[i] = cnt_r[i] + CNT_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (expire_s[i]) begin
              cnt_n_s[i]  = '0;
              led_n_s[i]  = 1'b0;
              busy_n_s[i] = 1'b0;
              tick_n_s[i] = 1'b1;
            end else begin
              cnt_n_s[i] = cnt_r[i] + CNT_W'(1);
            end
          end
          MODE_ON: begin
            cnt_n_s[i]  = '0;
            led_n_s[i]  = 1'b1;
            busy_n_s[i] = 1'b0;
          end
          default: begin
            cnt_n_s[i]  = '0;
            led_n_s[i]  = 1'b0;
            busy_n_s[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        period_r[i] <= CNT_W'(DEFAULT_PERIOD);
        cnt_r[i]    <= '0;
      end
      led_r  <= '0;
      tick_r <= '0;
      busy_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        period_r[i] <= period_n_s[i];
        cnt_r[i]    <= cnt_n_s[i];
      end
      led_r  <= led_n_s;
      tick_r <= tick_n_s;
      busy_r <= busy_n_s;
    end
  end

  assign led  = led_r;
  assign tick = tick_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_led_blinker_bank.sv
// Directed self-checking bench for led_blinker_bank (N_CH=4, CNT_W=8, DEFAULT_PERIOD=5).
// The sync_restart scenario is compiled in when LED_BLINK_SYNC_EN is defined.
module tb_led_blinker_bank;

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ONESHOT = 2'd3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = 2'd0;
  logic [7:0] wr_period = 8'd0;
  logic [1:0] wr_mode = 2'd0;
  logic [3:0] led, tick, busy;
`ifdef LED_BLINK_SYNC_EN
  logic       sync_restart = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int n = 0;

  led_blinker_bank #(.N_CH(4), .CNT_W(8), .DEFAULT_PERIOD(5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period), .wr_mode(wr_mode),
`ifdef LED_BLINK_SYNC_EN
    .sync_restart(sync_restart),
`endif
    .led(led), .tick(tick), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Untouched default channel: period 5 from reset, toggles at edges 5, 10, 15, ...
  function automatic logic base_led(input int e);
    return ((e / 5) % 2) == 1;
  endfunction
  function automatic logic base_tick(input int e);
    return (e > 0) && ((e % 5) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    n++;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] per, input logic [1:0] md);
    wr_en = 1'b1; wr_ch = ch; wr_period = per; wr_mode = md;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    // Asynchronous reset assertion before any clock edge.
    #1 sys_rst_n = 1'b0;
    #2;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #19 sys_rst_n = 1'b1;
    n = 0;

    // 1: default blink from reset
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_led_low", 32'(led), 32'h0);
      chk("t1_tick_low", 32'(tick), 32'h0);
    end
    step();
    chk("t1_tick_e5", 32'(tick), 32'hF);
    chk("t1_led_e5", 32'(led), 32'hF);
    for (int i = 6; i <= 9; i++) begin
      step();
      chk("t1_led_high", 32'(led), 32'hF);
      chk("t1_tick_hold", 32'(tick), 32'h0);
    end
    step();
    chk("t1_led_e10", 32'(led), 32'h0);
    chk("t1_tick_e10", 32'(tick), 32'hF);

    // 2: one-shot on ch1, period 3, written at edge 11
    do_write(2'd1, 8'd3, M_ONESHOT);
    chk("t2_led_start", 32'(led), 32'h2);
    chk("t2_busy_start", 32'(busy), 32'h2);
    chk("t2_tick_start", 32'(tick), 32'h0);
    step(); step();
    chk("t2_led_run", 32'(led), 32'h2);
    chk("t2_busy_run", 32'(busy), 32'h2);
    step();
    chk("t2_tick_end", 32'(tick), 32'h2);
    chk("t2_led_end", 32'(led), 32'h0);
    chk("t2_busy_end", 32'(busy), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t2_led1_idle", 32'(led[1]), 32'h0);
      chk("t2_busy1_idle", 32'(busy[1]), 32'h0);
      chk("t2_tick1_idle", 32'(tick[1]), 32'h0);
      chk("t2_led0_free", 32'(led[0]), 32'(base_led(n)));
    end

    // 3: ch2 blink with period 0 (acts as 1), written at edge 35
    do_write(2'd2, 8'd0, M_BLINK);
    chk("t3_led2_restart", 32'(led[2]), 32'h0);
    chk("t3_tick2_suppr", 32'(tick[2]), 32'h0);
    chk("t3_led0_e35", 32'(led[0]), 32'h1);
    chk("t3_tick0_e35", 32'(tick[0]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_tick2_cont", 32'(tick[2]), 32'h1);
      chk("t3_led2_toggle", 32'(led[2]), 32'((n % 2) == 0));
    end

    // 4: ch3 ON at edge 40, 12 cycles, then OFF
    do_write(2'd3, 8'd0, M_ON);
    chk("t4_led3_on", 32'(led[3]), 32'h1);
    chk("t4_tick3_on", 32'(tick[3]), 32'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t4_led3_hold", 32'(led[3]), 32'h1);
      chk("t4_tick3_zero", 32'(tick[3]), 32'h0);
      chk("t4_led0_free", 32'(led[0]), 32'(base_led(n)));
      chk("t4_tick0_free", 32'(tick[0]), 32'(base_tick(n)));
      chk("t4_led2_free", 32'(led[2]), 32'((n % 2) == 0));
    end
    do_write(2'd3, 8'd0, M_OFF);
    chk("t4_led3_off", 32'(led[3]), 32'h0);
    chk("t4_tick3_off", 32'(tick[3]), 32'h0);

    // 5: write ch0 on the expiry edge (55); write wins
    step();
    do_write(2'd0, 8'd5, M_BLINK);
    chk("t5_tick0_suppr", 32'(tick[0]), 32'h0);
    chk("t5_led0_restart", 32'(led[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_led0_wait", 32'(led[0]), 32'h0);
      chk("t5_tick0_wait", 32'(tick[0]), 32'h0);
    end
    step();
    chk("t5_led0_e60", 32'(led[0]), 32'h1);
    chk("t5_tick0_e60", 32'(tick[0]), 32'h1);
    do_write(2'd1, 8'd10, M_ONESHOT);
    chk("t5_busy_pre", 32'(busy), 32'h2);
    chk("t5_tick2_pre", 32'(tick[2]), 32'h1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("t5_async_led", 32'(led), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    chk("t5_async_tick", 32'(tick), 32'h0);
    #5 sys_rst_n = 1'b1;
    n = 0;

`ifdef LED_BLINK_SYNC_EN
    // 6: sync restart with a concurrent ch1 write
    step();
    do_write(2'd1, 8'd7, M_BLINK);
    sync_restart = 1'b1;
    do_write(2'd1, 8'd2, M_ONESHOT);
    sync_restart = 1'b0;
    chk("t6_led_sync", 32'(led), 32'h2);
    chk("t6_busy_sync", 32'(busy), 32'h2);
    chk("t6_tick_sync", 32'(tick), 32'h0);
    step(); step();
    chk("t6_tick_e5", 32'(tick), 32'h2);
    chk("t6_led_e5", 32'(led), 32'h0);
    step(); step();
    chk("t6_led_e7", 32'(led), 32'h0);
    step();
    chk("t6_tick_e8", 32'(tick), 32'hD);
    chk("t6_led_e8", 32'(led), 32'hD);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
